// File: rtl/ssd_scan_scheduler.sv
// ssd_scan_scheduler: eight-digit seven-segment scan controller with
// inter-digit blanking and frame-boundary arbitration between the score
// source (default owner) and an on-demand debug source.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_SCORE  | score source owns the display; debug grant checked at FB
// ST_DEBUG  | debug source owns the display for at least HOLD_FRAMES
module ssd_scan_scheduler #(
    parameter int DIGIT_CYCLES = 262144,
    parameter int BLANK_CYCLES = 4096,
    parameter int HOLD_FRAMES  = 4
) (
    input  logic        ClkPort,
    input  logic        Reset,
    input  logic [31:0] score_val_i,
    input  logic [7:0]  score_en_i,
    input  logic [7:0]  score_dp_i,
    input  logic        dbg_req_i,
    input  logic [31:0] dbg_val_i,
    output logic        dbg_ack_o,
    output logic        src_o,
    output logic [7:0]  An_o,
    output logic [6:0]  Seg_o,
    output logic        Dp_o
);

    localparam int             CW        = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_LAST  = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_BLANK = CW'(BLANK_CYCLES);
    localparam logic [7:0]     HOLD_MAX  = 8'(HOLD_FRAMES);
    localparam logic [7:0]     HOLD_REL  = 8'(HOLD_FRAMES - 1);

    typedef enum logic {
        ST_SCORE = 1'b0,
        ST_DEBUG = 1'b1
    } state_t;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic          fb;

    state_t        state_q;
    logic [7:0]    frame_cnt_q;
    logic [31:0]   frame_val_q;
    logic [7:0]    frame_en_q;
    logic [7:0]    frame_dp_q;

    logic [7:0]    an_q;
    logic [6:0]    seg_q;
    logic          dp_q;
    logic [3:0]    nib;

    // Hex digit to active-low {a,b,c,d,e,f,g}
    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    // Slot counter / digit index next-state and frame-boundary decode
    always_comb begin
        fb    = (cnt_q == CNT_LAST) && (idx_q == 3'd7);
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        idx_d = (cnt_q == CNT_LAST) ? idx_q + 3'd1 : idx_q;
    end

    // Slot counter and digit index registers
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    // Ownership FSM: decide at FB, then latch the new owner's frame content
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_SCORE;
            frame_cnt_q <= '0;
            frame_val_q <= '0;
            frame_en_q  <= '0;
            frame_dp_q  <= '0;
        end else if (fb) begin
            case (state_q)
                ST_SCORE: begin
                    if (dbg_req_i) begin
                        state_q     <= ST_DEBUG;
                        frame_cnt_q <= '0;
                        frame_val_q <= dbg_val_i;
                        frame_en_q  <= 8'hFF;
                        frame_dp_q  <= 8'h01;
                    end else begin
                        frame_val_q <= score_val_i;
                        frame_en_q  <= score_en_i;
                        frame_dp_q  <= score_dp_i;
                    end
                end
                default: begin
                    if (!dbg_req_i && (frame_cnt_q >= HOLD_REL)) begin
                        state_q     <= ST_SCORE;
                        frame_val_q <= score_val_i;
                        frame_en_q  <= score_en_i;
                        frame_dp_q  <= score_dp_i;
                    end else begin
                        if (frame_cnt_q < HOLD_MAX) begin
                            frame_cnt_q <= frame_cnt_q + 8'd1;
                        end
                        frame_val_q <= dbg_val_i;
                        frame_en_q  <= 8'hFF;
                        frame_dp_q  <= 8'h01;
                    end
                end
            endcase
        end
    end

    assign nib = frame_val_q[{idx_q, 2'b00} +: 4];

    // Registered display drive: dark during blanking or for disabled digits
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            an_q  <= 8'hFF;
            seg_q <= 7'h7F;
            dp_q  <= 1'b1;
        end else if ((cnt_q < CNT_BLANK) || !frame_en_q[idx_q]) begin
            an_q  <= 8'hFF;
            seg_q <= 7'h7F;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= ~(8'd1 << idx_q);
            seg_q <= hex7(nib);
            dp_q  <= ~frame_dp_q[idx_q];
        end
    end

    // The ack must be visible in the FB cycle itself, so it is decoded from
    // the registered counters/state and the live request rather than flopped.
    assign dbg_ack_o = fb && (state_q == ST_SCORE) && dbg_req_i;
    assign src_o     = (state_q == ST_DEBUG);
    assign An_o      = an_q;
    assign Seg_o     = seg_q;
    assign Dp_o      = dp_q;

endmodule
